// File: rtl/bayer_window_3x3_pkg.sv
// Bayer CFA encodings shared between the window generator and the interpolation stages.
package bayer_window_3x3_pkg;

  typedef enum logic [1:0] {
    PH_R  = 2'd0,
    PH_GR = 2'd1,
    PH_GB = 2'd2,
    PH_B  = 2'd3
  } bayer_phase_e;

  typedef enum logic [1:0] {
    BP_RGGB = 2'd0,
    BP_GRBG = 2'd1,
    BP_GBRG = 2'd2,
    BP_BGGR = 2'd3
  } bayer_pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Pattern bit 1 flips the row parity, bit 0 the column parity, relative to RGGB.
  function automatic bayer_phase_e bayer_phase(input logic row_odd, input logic col_odd,
                                               input bayer_pattern_e pattern);
    return bayer_phase_e'({row_odd ^ pattern[1], col_odd ^ pattern[0]});
  endfunction

endpackage

// File: rtl/bayer_window_3x3_if.sv
// Pixel stream in, 3x3 window plus centre phase out.
interface bayer_window_3x3_if #(
  parameter int DataBitWidth = 12
);
  logic                    sof;
  logic                    pix_valid;
  logic [DataBitWidth-1:0] pix_in;
  logic [DataBitWidth-1:0] win_m1_m1, win_m1_0, win_m1_p1;
  logic [DataBitWidth-1:0] win_0_m1,  win_0_0,  win_0_p1;
  logic [DataBitWidth-1:0] win_p1_m1, win_p1_0, win_p1_p1;
  logic [1:0]              phase;
  logic                    win_valid;
  logic                    frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_m1_m1, win_m1_0, win_m1_p1, win_0_m1, win_0_0, win_0_p1,
           win_p1_m1, win_p1_0, win_p1_p1, phase, win_valid, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_m1_m1, win_m1_0, win_m1_p1, win_0_m1, win_0_0, win_0_p1,
           win_p1_m1, win_p1_0, win_p1_p1, phase, win_valid, frame_done
  );
endinterface

// File: rtl/bayer_window_3x3_line_buffer_ram.sv
// One-line sample memory; the asynchronous read returns the old word in a write cycle.
module line_buffer_ram #(
  parameter int DataBitWidth = 12,
  parameter int Depth        = 640
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DataBitWidth-1:0]  wdata_i,
  output logic [DataBitWidth-1:0]  rdata_o
);
  logic [DataBitWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/bayer_window_3x3.sv
// Raster Bayer stream to registered 3x3 neighbourhood with centre colour phase.
// state     | meaning
// ST_IDLE   | no frame in progress, pixels without sof are dropped
// ST_ACTIVE | frame in progress, every valid pixel is consumed
module bayer_window_3x3
  import bayer_window_3x3_pkg::*;
#(
  parameter int DataBitWidth = 12,
  parameter int ImgWidth     = 640,
  parameter int ImgHeight    = 480,
  parameter int BayerPattern = 0
) (
  input  logic               clk,
  input  logic               rst,
  bayer_window_3x3_if.slave  bus
);
  localparam int CW = $clog2(ImgWidth);
  localparam int RW = $clog2(ImgHeight);
  localparam logic [CW-1:0] COL_LAST = CW'(ImgWidth - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ImgHeight - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(2);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(2);
  localparam bayer_pattern_e BP = bayer_pattern_e'(2'(BayerPattern));

  frame_state_e            state_q, state_d;
  logic [CW-1:0]           col_q, col_d, col_cur;
  logic [RW-1:0]           row_q, row_d, row_cur;
  logic                    acc, emit, last_pix;
  logic [DataBitWidth-1:0] lb0_rd, lb1_rd;
  logic [DataBitWidth-1:0] col_new [3];
  logic [DataBitWidth-1:0] hist_q  [3][2];
  logic [DataBitWidth-1:0] win_q   [3][3];
  bayer_phase_e            phase_q;
  logic                    win_valid_q, done_pend_q, frame_done_q;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    col_cur  = bus.sof ? '0 : col_q;
    row_cur  = bus.sof ? '0 : row_q;
    acc      = bus.pix_valid && (bus.sof || (state_q == ST_ACTIVE));
    last_pix = acc && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    emit     = acc && (row_cur >= ROW_WIN0) && (col_cur >= COL_WIN0);
    case (state_q)
      ST_IDLE:   if (acc) state_d = ST_ACTIVE;
      ST_ACTIVE: if (last_pix) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (acc) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  line_buffer_ram #(.DataBitWidth(DataBitWidth), .Depth(ImgWidth)) u_lb0 (
    .clk(clk), .we_i(acc), .addr_i(col_cur), .wdata_i(bus.pix_in), .rdata_o(lb0_rd)
  );

  line_buffer_ram #(.DataBitWidth(DataBitWidth), .Depth(ImgWidth)) u_lb1 (
    .clk(clk), .we_i(acc), .addr_i(col_cur), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
  );

  assign col_new[0] = lb1_rd;
  assign col_new[1] = lb0_rd;
  assign col_new[2] = bus.pix_in;

  // Two history columns suffice; the third window column is the incoming one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) hist_q[r][c] <= '0;
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
      phase_q      <= PH_R;
      win_valid_q  <= 1'b0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= emit;
      done_pend_q  <= last_pix;
      frame_done_q <= done_pend_q;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          hist_q[r][0] <= hist_q[r][1];
          hist_q[r][1] <= col_new[r];
        end
      end
      if (emit) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= hist_q[r][0];
          win_q[r][1] <= hist_q[r][1];
          win_q[r][2] <= col_new[r];
        end
        phase_q <= bayer_phase(~row_cur[0], ~col_cur[0], BP);
      end
    end
  end

  assign bus.win_m1_m1  = win_q[0][0];
  assign bus.win_m1_0   = win_q[0][1];
  assign bus.win_m1_p1  = win_q[0][2];
  assign bus.win_0_m1   = win_q[1][0];
  assign bus.win_0_0    = win_q[1][1];
  assign bus.win_0_p1   = win_q[1][2];
  assign bus.win_p1_m1  = win_q[2][0];
  assign bus.win_p1_0   = win_q[2][1];
  assign bus.win_p1_p1  = win_q[2][2];
  assign bus.phase      = phase_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bayer_window_3x3.sv
// Randomised-gap frame stimulus checked against an image-level window model.
module tb_bayer_window_3x3;
  import bayer_window_3x3_pkg::*;

  localparam int DW = 12;
  localparam int W  = 8;
  localparam int H  = 6;

  typedef struct packed {
    logic [8:0][DW-1:0] w;
    logic [7:0]         r;
    logic [7:0]         c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad = 0;
  int   strobe_cnt = 0;
  int   done_cnt = 0;
  int   pv_count = 0;
  int   s0, d0;
  logic pv_last = 1'b0;
  logic done_pending = 1'b0;
  logic mon_next_done;
  logic first_seen = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Colour at (row parity, col parity) for each CFA pattern: R=0, Gr=1, Gb=2, B=3.
  int cfa_lut [4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}};

  bayer_window_3x3_if #(.DataBitWidth(DW)) bif ();
  assign bif.sof       = sof;
  assign bif.pix_valid = pix_valid;
  assign bif.pix_in    = pix_in;

  bayer_window_3x3 #(.DataBitWidth(DW), .ImgWidth(W), .ImgHeight(H), .BayerPattern(0)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  logic [3:0][1:0] ph_x;
  logic [3:0]      wv_x;
  assign ph_x[0] = bif.phase;
  assign wv_x[0] = bif.win_valid;

  for (genvar g = 1; g < 4; g++) begin : g_pat
    bayer_window_3x3_if #(.DataBitWidth(DW)) pif ();
    assign pif.sof       = sof;
    assign pif.pix_valid = pix_valid;
    assign pif.pix_in    = pix_in;
    bayer_window_3x3 #(.DataBitWidth(DW), .ImgWidth(W), .ImgHeight(H), .BayerPattern(g)) dut_p (
      .clk(clk), .rst(rst), .bus(pif)
    );
    assign ph_x[g] = pif.phase;
    assign wv_x[g] = pif.win_valid;
  end

  logic [8:0][DW-1:0] mon_got;
  assign mon_got = {bif.win_p1_p1, bif.win_p1_0, bif.win_p1_m1,
                    bif.win_0_p1,  bif.win_0_0,  bif.win_0_m1,
                    bif.win_m1_p1, bif.win_m1_0, bif.win_m1_m1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix_val(input int tag, input int r, input int c);
    return DW'(tag * 256 + r * 16 + c);
  endfunction

  task automatic push_window(input int tag, input int r, input int c);
    exp_t e;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        e.w[(dr + 1) * 3 + (dc + 1)] = pix_val(tag, r + dr, c + dc);
    e.r = 8'(r);
    e.c = 8'(c);
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input logic s, input logic v, input logic [DW-1:0] d);
    sof       = s;
    pix_valid = v;
    pix_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, '0);
  endtask

  // Sends the first n pixels of a frame; a window is expected once its bottom-right pixel is in.
  task automatic send_frame(input int tag, input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      int r = i / W;
      int c = i % W;
      if (gappy)
        for (int k = 0; k < 8 && $urandom_range(99) < 40; k++)
          drive_cycle(1'($urandom_range(1)), 1'b0, DW'($urandom));
      if (r >= 2 && c >= 2) push_window(tag, r - 1, c - 1);
      drive_cycle(i == 0, 1'b1, pix_val(tag, r, c));
    end
  endtask

  always @(posedge clk) begin
    pv_last <= pix_valid;
    if (pix_valid) pv_count <= pv_count + 1;
  end

  always @(negedge clk) begin
    mon_next_done = 1'b0;
    check_val("frame_done", bif.frame_done, done_pending);
    if (bif.frame_done) done_cnt++;
    if (!pv_last) check_val("gap_strobe", bif.win_valid, 0);
    check_val("pat_valid", wv_x, {4{bif.win_valid}});
    if (bif.win_valid) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexp_strobe", bif.win_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int k = 0; k < 9; k++)
          check_val($sformatf("tap%0d_r%0d_c%0d", k, mon_e.r, mon_e.c), mon_got[k], mon_e.w[k]);
        for (int g = 0; g < 4; g++)
          check_val($sformatf("phase_p%0d_r%0d_c%0d", g, mon_e.r, mon_e.c), ph_x[g],
                    cfa_lut[g][(mon_e.r % 2) * 2 + (mon_e.c % 2)]);
        if (!first_seen) begin
          first_seen = 1'b1;
          check_val("first_after_px", pv_count, 19);
          check_val("first_m1_m1", bif.win_m1_m1, 0);
          check_val("first_0_0", bif.win_0_0, 17);
          check_val("first_0_p1", bif.win_0_p1, 18);
          check_val("first_p1_p1", bif.win_p1_p1, 34);
          check_val("first_phase", bif.phase, 3);
        end
        mon_next_done = (mon_e.r == 8'(H - 2)) && (mon_e.c == 8'(W - 2));
      end
    end
    done_pending = mon_next_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    check_val("rst_valid", bif.win_valid, 0);
    check_val("rst_0_0", bif.win_0_0, 0);
    check_val("rst_phase", bif.phase, 0);
    check_val("rst_done", bif.frame_done, 0);

    // continuous frame
    s0 = strobe_cnt; d0 = done_cnt;
    send_frame(0, W * H, 1'b0);
    idle(4);
    check_val("s1_strobes", strobe_cnt - s0, 24);
    check_val("s1_done", done_cnt - d0, 1);

    // gapped frame
    s0 = strobe_cnt; d0 = done_cnt;
    send_frame(1, W * H, 1'b1);
    idle(4);
    check_val("s2_strobes", strobe_cnt - s0, 24);
    check_val("s2_done", done_cnt - d0, 1);

    // sof re-asserted at pixel (3,4)
    s0 = strobe_cnt; d0 = done_cnt;
    send_frame(2, 3 * W + 4, 1'b0);
    send_frame(3, W * H, 1'b1);
    idle(4);
    check_val("s4_strobes", strobe_cnt - s0, 8 + 24);
    check_val("s4_done", done_cnt - d0, 1);

    // asynchronous reset mid-frame, then sof-less pixels
    s0 = strobe_cnt; d0 = done_cnt;
    send_frame(4, 30, 1'b0);
    idle(3);
    #2 rst = 1'b0;
    #1;
    check_val("arst_0_0", bif.win_0_0, 0);
    check_val("arst_p1_p1", bif.win_p1_p1, 0);
    check_val("arst_m1_m1", bif.win_m1_m1, 0);
    check_val("arst_valid", bif.win_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, DW'($urandom));
    idle(3);
    check_val("s5_no_sof_strobes", strobe_cnt - s0, 10);
    send_frame(5, W * H, 1'b1);
    idle(4);
    check_val("s5_strobes", strobe_cnt - s0, 10 + 24);
    check_val("s5_done", done_cnt - d0, 1);

    // back-to-back frames
    s0 = strobe_cnt; d0 = done_cnt;
    send_frame(6, W * H, 1'b0);
    send_frame(7, W * H, 1'b0);
    idle(4);
    check_val("s6_strobes", strobe_cnt - s0, 48);
    check_val("s6_done", done_cnt - d0, 2);

    check_val("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
